// File: rtl/mlp_train_sequencer_pkg.sv
// Shared definitions for the MLP training sequencer.
//   FixedPoint             : signed Q8.8 number format (sfp), ONE, HALF, int_to_sfp()
//   Common                 : sequencer state encoding (seq_state_t)
//   mlp_train_sequencer_pkg: widths local to the sequencer
package FixedPoint;
  localparam int SFP_W = 16;
  localparam int FRAC  = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE  = 16'sh0100;
  localparam sfp HALF = 16'sh0080;

  function automatic sfp int_to_sfp(input int x);
    return sfp'(x <<< FRAC);
  endfunction
endpackage

package Common;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_EVAL  = 2'd2,
    ST_INFER = 2'd3
  } seq_state_t;
endpackage

package mlp_train_sequencer_pkg;
  localparam int EPOCH_W = 16;
endpackage

// File: rtl/mlp_sample_rom.sv
// Combinational sample encoder: training-set index -> network input vector and
// target vector.
//   i_idx      : sample index; bit i drives input i
//   o_values   : values[i] = ONE when bit i of the index is set, else 0
//   o_expected : expected[o] = ONE when TRUTH[idx*OUTPUTS+o] is set, else 0
module mlp_sample_rom
  import FixedPoint::*;
#(
  parameter int                             INPUTS  = 2,
  parameter int                             OUTPUTS = 1,
  parameter logic [(2**INPUTS)*OUTPUTS-1:0] TRUTH   = 4'b1000
) (
  input  logic [INPUTS-1:0] i_idx,
  output sfp   [INPUTS-1:0] o_values,
  output sfp   [OUTPUTS-1:0] o_expected
);
  logic [OUTPUTS-1:0] w_row;

  // The targets for one sample are a contiguous OUTPUTS-wide row of TRUTH.
  assign w_row = OUTPUTS'(TRUTH >> (int'(i_idx) * OUTPUTS));

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    o_values   = '0;
    o_expected = '0;
    for (int i = 0; i < INPUTS; i++)  o_values[i]   = i_idx[i] ? ONE : '0;
    for (int o = 0; o < OUTPUTS; o++) o_expected[o] = w_row[o] ? ONE : '0;
  end
endmodule

// File: rtl/mlp_train_sequencer.sv
// Training sequencer for a small MLP: feeds every truth-table sample to the
// network for EPOCHS passes with training enabled, optionally scores the
// trained network, then streams live switch inputs for inference.
// Optional feature macro: MLP_SEQ_EVAL_EN (EVAL state, correct_o, pass_o).
//   clk, rst            : clock, synchronous active-high reset
//   start               : leaves IDLE
//   live_in             : switch inputs used in INFER
//   values, expected    : sample presented to the network
//   training            : network weight-update enable
//   net_valid/net_ready : sample handshake
//   prediction/pred_valid : network result and strobe
//   leds                : prediction[o] > HALF from the last INFER result
//   state_o, epoch_o, correct_o, pass_o : status
module mlp_train_sequencer
  import FixedPoint::*;
  import Common::*;
  import mlp_train_sequencer_pkg::*;
#(
  parameter int                             INPUTS  = 2,
  parameter int                             OUTPUTS = 1,
  parameter int                             EPOCHS  = 10,
  parameter logic [(2**INPUTS)*OUTPUTS-1:0] TRUTH   = 4'b1000
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [INPUTS-1:0]                            live_in,
  output sfp   [INPUTS-1:0]                            values,
  output sfp   [OUTPUTS-1:0]                           expected,
  output logic                                         training,
  output logic                                         net_valid,
  input  logic                                         net_ready,
  input  sfp   [OUTPUTS-1:0]                           prediction,
  input  logic                                         pred_valid,
  output logic [OUTPUTS-1:0]                           leds,
  output logic [1:0]                                   state_o,
  output logic [EPOCH_W-1:0]                           epoch_o,
  output logic [$clog2((2**INPUTS)*OUTPUTS+1)-1:0]     correct_o,
  output logic                                         pass_o
);
  localparam int SAMPLES = 2**INPUTS;
  localparam int CW      = $clog2(SAMPLES*OUTPUTS+1);

  seq_state_t          r_state;
  logic [INPUTS-1:0]   r_idx;
  logic [EPOCH_W-1:0]  r_epoch;
  logic                r_valid;
  logic                r_busy;      // accepted by the network, result pending
  logic                r_training;
  sfp   [INPUTS-1:0]   r_values;
  sfp   [OUTPUTS-1:0]  r_expected;
  logic [OUTPUTS-1:0]  r_leds;

  sfp   [INPUTS-1:0]   w_rom_values;
  sfp   [OUTPUTS-1:0]  w_rom_expected;
  sfp   [INPUTS-1:0]   w_next_values;
  sfp   [OUTPUTS-1:0]  w_next_expected;
  logic [OUTPUTS-1:0]  w_pred_hi;
  logic                w_launch;
  logic                w_result;
  logic                w_last_idx;

  mlp_sample_rom #(.INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .TRUTH(TRUTH)) u_rom (
    .i_idx      (r_idx),
    .o_values   (w_rom_values),
    .o_expected (w_rom_expected)
  );

  // A new sample is launched only when nothing is presented or outstanding,
  // so at most one transaction is ever in flight.
  assign w_launch   = (r_state != ST_IDLE) && !r_valid && !r_busy;
  // pred_valid with no outstanding transaction is ignored.
  assign w_result   = pred_valid && r_busy;
  assign w_last_idx = (r_idx == INPUTS'(SAMPLES-1));

  always_comb begin
    w_next_values   = w_rom_values;
    w_next_expected = w_rom_expected;
    w_pred_hi       = '0;
    if (r_state == ST_INFER) begin
      w_next_expected = '0;
      for (int i = 0; i < INPUTS; i++) w_next_values[i] = int_to_sfp(int'(live_in[i]));
    end
    // Signed threshold; exactly HALF counts as low.
    for (int o = 0; o < OUTPUTS; o++) w_pred_hi[o] = $signed(prediction[o]) > $signed(HALF);
  end

`ifdef MLP_SEQ_EVAL_EN
  logic [CW-1:0] r_correct;
  logic          r_pass;
  logic [CW-1:0] w_hits;

  // The registered expected vector still holds the targets of the outstanding
  // sample, so scoring needs no second ROM lookup.
  always_comb begin
    w_hits = '0;
    for (int o = 0; o < OUTPUTS; o++)
      if (w_pred_hi[o] == (r_expected[o] == ONE)) w_hits = w_hits + CW'(1);
  end

  assign correct_o = r_correct;
  assign pass_o    = r_pass;
`else
  assign correct_o = '0;
  assign pass_o    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_epoch    <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_training <= 1'b0;
      r_values   <= '0;
      r_expected <= '0;
      r_leds     <= '0;
`ifdef MLP_SEQ_EVAL_EN
      r_correct  <= '0;
      r_pass     <= 1'b0;
`endif
    end else begin
      if (r_valid && net_ready) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b1;
      end else if (w_launch) begin
        r_valid    <= 1'b1;
        r_values   <= w_next_values;
        r_expected <= w_next_expected;
      end
      if (w_result) r_busy <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_TRAIN;
            r_training <= 1'b1;
            r_idx      <= '0;
            r_epoch    <= '0;
          end
        end
        ST_TRAIN: begin
          if (w_result) begin
            r_idx <= r_idx + INPUTS'(1);
            if (w_last_idx) begin
              r_epoch <= r_epoch + EPOCH_W'(1);
              if (r_epoch == EPOCH_W'(EPOCHS-1)) begin
                r_training <= 1'b0;
`ifdef MLP_SEQ_EVAL_EN
                r_state    <= ST_EVAL;
`else
                r_state    <= ST_INFER;
`endif
              end
            end
          end
        end
`ifdef MLP_SEQ_EVAL_EN
        ST_EVAL: begin
          if (w_result) begin
            r_idx     <= r_idx + INPUTS'(1);
            r_correct <= r_correct + w_hits;
            if (w_last_idx) begin
              r_pass  <= ((r_correct + w_hits) == CW'(SAMPLES*OUTPUTS));
              r_state <= ST_INFER;
            end
          end
        end
`endif
        ST_INFER: begin
          if (w_result) r_leds <= w_pred_hi;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign values    = r_values;
  assign expected  = r_expected;
  assign training  = r_training;
  assign net_valid = r_valid;
  assign leds      = r_leds;
  assign state_o   = r_state;
  assign epoch_o   = r_epoch;
endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer (default parameters: 2 inputs,
// 1 output, 10 epochs, AND truth table). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_mlp_train_sequencer;
  import FixedPoint::*;

  localparam logic [15:0] K_ONE  = 16'h0100;
  localparam logic [15:0] K_HALF = 16'h0080;

  logic        clk = 1'b0;
  logic        rst, start, net_ready, pred_valid;
  logic [1:0]  live_in;
  sfp   [1:0]  values;
  sfp   [0:0]  expected;
  sfp   [0:0]  prediction;
  logic        training, net_valid, pass_o;
  logic [0:0]  leds;
  logic [1:0]  state_o;
  logic [15:0] epoch_o;
  logic [2:0]  correct_o;

  int checks = 0;
  int errors = 0;
  int txns   = 0;
  logic [15:0] t_v0, t_v1, t_e, t_ep;
  logic        t_tr;

  always #5 clk = ~clk;

  mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .EPOCHS(10), .TRUTH(4'b1000)) dut (
    .clk(clk), .rst(rst), .start(start), .live_in(live_in),
    .values(values), .expected(expected), .training(training),
    .net_valid(net_valid), .net_ready(net_ready),
    .prediction(prediction), .pred_valid(pred_valid), .leds(leds),
    .state_o(state_o), .epoch_o(epoch_o), .correct_o(correct_o), .pass_o(pass_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: wait for net_valid, hold ready low for lo cycles
  // (values must stay put), accept, then return the result one cycle later.
  task automatic txn(input int lo, input logic [15:0] p);
    int n;
    n = 0;
    while (net_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (net_valid !== 1'b1) begin
      check("valid_timeout", {31'd0, net_valid}, 32'd1);
      return;
    end
    t_v0 = values[0];
    t_v1 = values[1];
    t_e  = expected[0];
    t_ep = epoch_o;
    t_tr = training;
    for (int k = 0; k < lo; k++) begin
      net_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, net_valid}, 32'd1);
      check("hold_v0", values[0], t_v0);
      check("hold_v1", values[1], t_v1);
    end
    net_ready = 1'b1;
    @(negedge clk);
    net_ready = 1'b0;
    check("valid_drops", {31'd0, net_valid}, 32'd0);
    prediction[0] = p;
    pred_valid    = 1'b1;
    @(negedge clk);
    pred_valid = 1'b0;
    txns++;
  endtask

  task automatic train_txn(input int e, input int s, input int lo);
    logic [1:0] sb;
    sb = 2'(s);
    txn(lo, 16'h0000);
    check("tr_v0", t_v0, sb[0] ? K_ONE : 16'h0000);
    check("tr_v1", t_v1, sb[1] ? K_ONE : 16'h0000);
    check("tr_exp", t_e, (s == 3) ? K_ONE : 16'h0000);
    check("tr_epoch", t_ep, 16'(e));
    check("tr_training", {31'd0, t_tr}, 32'd1);
  endtask

  task automatic do_reset_start();
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic train_all();
    for (int e = 0; e < 10; e++)
      for (int s = 0; s < 4; s++) train_txn(e, s, 0);
  endtask

`ifdef MLP_SEQ_EVAL_EN
  task automatic eval_all(input logic [15:0] p3);
    logic [1:0] sb;
    for (int s = 0; s < 4; s++) begin
      sb = 2'(s);
      txn(0, (s == 3) ? p3 : 16'h0000);
      check("ev_v0", t_v0, sb[0] ? K_ONE : 16'h0000);
      check("ev_v1", t_v1, sb[1] ? K_ONE : 16'h0000);
      check("ev_training", {31'd0, t_tr}, 32'd0);
      if (s == 0) check("ev_correct_first", correct_o, 32'd1);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; net_ready = 1'b0; pred_valid = 1'b0;
    live_in = 2'b00; prediction = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_state", state_o, 32'd0);
    check("rst_valid", {31'd0, net_valid}, 32'd0);
    check("rst_training", {31'd0, training}, 32'd0);
    check("rst_epoch", epoch_o, 32'd0);
    check("rst_leds", leds, 32'd0);
    check("rst_values", values, 32'd0);
    check("rst_expected", expected, 32'd0);
    check("rst_correct", correct_o, 32'd0);
    check("rst_pass", {31'd0, pass_o}, 32'd0);

    // Start: IDLE -> TRAIN
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_state", state_o, 32'd1);
    check("start_training", {31'd0, training}, 32'd1);

    // 10 epochs; sample 2 of epoch 0 is back-pressured for 5 cycles
    txns = 0;
    for (int e = 0; e < 10; e++) begin
      for (int s = 0; s < 4; s++) begin
        train_txn(e, s, (e == 0 && s == 2) ? 5 : 0);
        if (e == 2 && s == 0) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          check("start_ignored_train", state_o, 32'd1);
        end
      end
    end
    check("train_txn_count", txns, 32'd40);
    check("train_epoch_final", epoch_o, 32'd10);
    check("train_done_training", {31'd0, training}, 32'd0);

`ifdef MLP_SEQ_EVAL_EN
    check("to_eval_state", state_o, 32'd2);
    eval_all(K_ONE);
    check("eval_correct_all", correct_o, 32'd4);
    check("eval_pass_all", {31'd0, pass_o}, 32'd1);
    check("eval_to_infer", state_o, 32'd3);

    do_reset_start();
    check("rerun_pass_cleared", {31'd0, pass_o}, 32'd0);
    train_all();
    check("rerun_state_eval", state_o, 32'd2);
    eval_all(16'h0000);
    check("eval_correct_miss", correct_o, 32'd3);
    check("eval_pass_miss", {31'd0, pass_o}, 32'd0);
    check("eval_miss_to_infer", state_o, 32'd3);
`else
    check("train_to_infer", state_o, 32'd3);
    check("noeval_pass", {31'd0, pass_o}, 32'd0);
    check("noeval_correct", correct_o, 32'd0);
`endif

    // INFER
    live_in = 2'b11;
    txn(0, K_ONE);
    check("inf11_v0", t_v0, K_ONE);
    check("inf11_v1", t_v1, K_ONE);
    check("inf11_training", {31'd0, t_tr}, 32'd0);
    check("inf_leds_one", leds, 32'd1);

    live_in = 2'b01;
    txn(0, K_HALF);
    check("inf01_v0", t_v0, K_ONE);
    check("inf01_v1", t_v1, 16'h0000);
    check("inf_leds_half", leds, 32'd0);

    live_in = 2'b10;
    txn(0, K_HALF + 16'h0001);
    check("inf10_v0", t_v0, 16'h0000);
    check("inf10_v1", t_v1, K_ONE);
    check("inf_leds_above_half", leds, 32'd1);

    txn(0, 16'hFF00);
    check("inf_leds_negative", leds, 32'd0);

    // Spurious pred_valid while a sample is presented but not accepted
    @(negedge clk);
    check("spur_valid_pending", {31'd0, net_valid}, 32'd1);
    prediction[0] = K_ONE;
    pred_valid    = 1'b1;
    @(negedge clk);
    pred_valid = 1'b0;
    @(negedge clk);
    check("spur_leds", leds, 32'd0);
    check("spur_valid_held", {31'd0, net_valid}, 32'd1);
    txn(0, 16'h0000);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_infer", state_o, 32'd3);
    check("infer_pass_stable", {31'd0, pass_o},
`ifdef MLP_SEQ_EVAL_EN
          32'd0
`else
          32'd0
`endif
    );

    // Reset mid-TRAIN at epoch 4, with start and pred_valid also high
    do_reset_start();
    for (int e = 0; e < 4; e++)
      for (int s = 0; s < 4; s++) train_txn(e, s, 0);
    train_txn(4, 0, 0);
    train_txn(4, 1, 0);
    @(negedge clk);
    check("pre_rst_epoch", epoch_o, 32'd4);
    check("pre_rst_valid", {31'd0, net_valid}, 32'd1);
    rst = 1'b1; start = 1'b1; pred_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; pred_valid = 1'b0;
    check("mid_rst_state", state_o, 32'd0);
    check("mid_rst_epoch", epoch_o, 32'd0);
    check("mid_rst_valid", {31'd0, net_valid}, 32'd0);
    check("mid_rst_training", {31'd0, training}, 32'd0);
    check("mid_rst_values", values, 32'd0);
    @(negedge clk);
    check("mid_rst_idle_holds", state_o, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_state", state_o, 32'd1);
    train_txn(0, 0, 0);
    train_txn(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mlp_train_sequencer.md
MLP_TRAIN_SEQUENCER -- requirements
Module: mlp_train_sequencer

Interface
REQ-001 SHALL have parameter INPUTS, default 2, number of network inputs; SAMPLES = 2**INPUTS.
REQ-002 SHALL have parameter OUTPUTS, default 1, number of network outputs.
REQ-003 SHALL have parameter EPOCHS, default 10, training passes over the full dataset; legal range 1..65535.
REQ-004 SHALL have parameter TRUTH [SAMPLES*OUTPUTS-1:0], default 4'b1000 (AND); bit s*OUTPUTS+o is the target of output o for sample index s.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1; reset rst, synchronous, active-high.
REQ-007 SHALL have port start, input, 1, begin training when high in IDLE.
REQ-008 SHALL have port live_in, input, INPUTS, switch inputs used in inference.
REQ-009 SHALL have port values, output, INPUTS x sfp, network input vector.
REQ-010 SHALL have port expected, output, OUTPUTS x sfp, training targets.
REQ-011 SHALL have port training, output, 1, network update enable.
REQ-012 SHALL have port net_valid / net_ready, output / input, 1 each, sample handshake to network.
REQ-013 SHALL have port prediction / pred_valid, input, OUTPUTS x sfp / 1, network result and its strobe.
REQ-014 SHALL have port leds, output, OUTPUTS, thresholded live prediction.
REQ-015 SHALL have ports state_o (2), epoch_o (16), correct_o ($clog2(SAMPLES*OUTPUTS+1)) and pass_o (1), all outputs.

Function
REQ-016 SHALL implement states IDLE, TRAIN, EVAL, INFER with encoding 0..3, exposed on state_o.
REQ-017 SHALL move IDLE->TRAIN on start=1; start in any other state SHALL be ignored.
REQ-018 SHALL drive sample index s as values[i] = ONE when bit i of s is set and 0 otherwise, with expected[o] = ONE/0 taken from TRUTH.
REQ-019 SHALL hold net_valid high with stable values/expected until the cycle in which net_valid and net_ready are both high.
REQ-020 SHALL allow exactly one outstanding transaction; the next net_valid SHALL assert no earlier than the cycle after pred_valid.
REQ-021 In TRAIN, SHALL assert training=1, issue indices 0..SAMPLES-1 in order, and on index wrap increment epoch_o.
REQ-022 SHALL leave TRAIN on the pred_valid that completes epoch EPOCHS-1, going to EVAL when compiled in and to INFER otherwise.
REQ-023 In EVAL, SHALL assert training=0, issue each index once, and increment correct_o for each output where (prediction[o] > HALF) equals the TRUTH bit.
REQ-024 After the last EVAL result, SHALL set pass_o = (correct_o == SAMPLES*OUTPUTS) and enter INFER.
REQ-025 In INFER, SHALL assert training=0, issue values[i] = int_to_sfp(live_in[i]) continuously, and update leds[o] = prediction[o] > HALF one cycle after each pred_valid.
REQ-026 SHALL ignore pred_valid when no transaction is outstanding.
REQ-027 The comparison against HALF SHALL be signed; a prediction equal to HALF SHALL give 0.

Reset
REQ-028 On rst=1 at a clock edge, SHALL enter IDLE and clear net_valid, training, leds, epoch_o, correct_o and pass_o, and set values and expected to 0, abandoning any outstanding transaction.
REQ-029 rst SHALL take priority over start and pred_valid in the same cycle.

Configuration
REQ-030 With macro MLP_SEQ_EVAL_EN defined, the EVAL state, correct_o and pass_o SHALL be implemented.
REQ-031 Without MLP_SEQ_EVAL_EN, TRAIN SHALL go directly to INFER, correct_o SHALL be tied to 0 and pass_o to 0, and state 2 SHALL be unreachable.

Structure
REQ-032 sfp, ONE, HALF and int_to_sfp SHALL come from FixedPoint, and the state enum (seq_state_t) SHALL be added to Common.
REQ-033 Sample encoding (index -> values/expected) SHALL be a sub-module, mlp_sample_rom, combinational and parametrised by INPUTS, OUTPUTS and TRUTH.

Verification
REQ-034 Defaults, start pulse, net_ready=1, pred_valid one cycle after each accept -> exactly 40 training transactions, epoch_o=10, then EVAL.
REQ-035 net_ready held low for 5 cycles during sample 2 -> values={ONE,0} stable throughout and no index skipped.
REQ-036 EVAL with predictions ONE for index 3 and 0 for indices 0..2 -> correct_o=4 and pass_o=1; with index 3 forced to 0 -> correct_o=3 and pass_o=0.
REQ-037 INFER with live_in=2'b11 and prediction=ONE -> leds=1; with prediction=HALF -> leds=0.
REQ-038 rst asserted mid-TRAIN at epoch 4 -> next cycle state_o=IDLE, epoch_o=0, net_valid=0; a new start restarts at index 0.
REQ-039 Build without MLP_SEQ_EVAL_EN -> state_o goes 1->3 directly and pass_o stays 0.
